// File: rtl/quad_byte_assembler.sv
// Big-endian byte stream to RAM datum assembler.
// Collects 1/2/4/8 bytes, then holds an extended word for the consumer.
package quad_byte_assembler_pkg;
    typedef logic [2:0] data_type_t;
    localparam data_type_t RAM_BYTE = 3'd0;
    localparam data_type_t RAM_WORD = 3'd1;
    localparam data_type_t RAM_LONG = 3'd2;
    localparam data_type_t RAM_QUAD = 3'd3;
endpackage

module quad_byte_assembler
    import quad_byte_assembler_pkg::*;
#(
    parameter int OUT_BYTES = 8,
    parameter int BYTE_SIZE = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BYTE_SIZE-1:0]           in_byte,
    input  data_type_t                     data_type,
    input  logic                           sign_ext,
    input  logic                           align_high,
    input  logic                           abort,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_BYTES*BYTE_SIZE-1:0] data_out,
    output logic [3:0]                     byte_cnt
);

    localparam int SR_W  = 8 * BYTE_SIZE;
    localparam int OUT_W = OUT_BYTES * BYTE_SIZE;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    logic [0:0]           state;
    logic [SR_W-BYTE_SIZE-1:0] sr;
    logic [SR_W-1:0]      sr_next;
    logic [3:0]           n_in;
    logic [3:0]           n_lat;
    logic [3:0]           n_eff;
    logic [3:0]           cnt_next;
    logic                 sx_lat;
    logic                 ah_lat;
    logic                 sx_eff;
    logic                 ah_eff;
    logic                 first;
    logic                 accept;
    logic                 done;
    logic                 sign;
    logic [BYTE_SIZE-1:0] vb [8];
    logic [OUT_W-1:0]     fmt;

    always_comb begin
        unique case (data_type)
            RAM_BYTE: n_in = 4'd1;
            RAM_WORD: n_in = 4'd2;
            RAM_LONG: n_in = 4'd4;
            default:  n_in = 4'd8;
        endcase
    end

    assign in_ready  = (state == COLLECT) && !abort;
    assign out_valid = (state == HOLD) && !abort;
    assign accept    = in_valid && in_ready;

    // The first byte's accept uses live mode inputs; later ones the latch.
    assign first    = (byte_cnt == 4'd0);
    assign n_eff    = first ? n_in : n_lat;
    assign sx_eff   = first ? sign_ext : sx_lat;
    assign ah_eff   = first ? align_high : ah_lat;
    assign sr_next  = {sr, in_byte};
    assign cnt_next = byte_cnt + 4'd1;
    assign done     = (cnt_next == n_eff);

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            vb[k] = sr_next[k*BYTE_SIZE +: BYTE_SIZE];
        end
        sign = vb[3'(n_eff - 4'd1)][BYTE_SIZE-1];
        fmt  = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (ah_eff) begin
                if (i >= OUT_BYTES - int'(n_eff)) begin
                    fmt[i*BYTE_SIZE +: BYTE_SIZE] =
                        vb[3'(i - OUT_BYTES + int'(n_eff))];
                end
            end else if (i < int'(n_eff)) begin
                fmt[i*BYTE_SIZE +: BYTE_SIZE] = vb[3'(i)];
            end else if (sx_eff && sign) begin
                fmt[i*BYTE_SIZE +: BYTE_SIZE] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COLLECT;
            byte_cnt <= 4'd0;
            data_out <= '0;
            sr       <= '0;
            n_lat    <= 4'd8;
            sx_lat   <= 1'b0;
            ah_lat   <= 1'b0;
        end else if (abort) begin
            state    <= COLLECT;
            byte_cnt <= 4'd0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                state    <= COLLECT;
                byte_cnt <= 4'd0;
            end
        end else if (accept) begin
            sr       <= sr_next[SR_W-BYTE_SIZE-1:0];
            byte_cnt <= cnt_next;
            if (first) begin
                n_lat  <= n_in;
                sx_lat <= sign_ext;
                ah_lat <= align_high;
            end
            if (done) begin
                state    <= HOLD;
                data_out <= fmt;
            end
        end
    end

endmodule

// File: tb/tb_quad_byte_assembler.sv
// Bench for quad_byte_assembler: directed literals plus random traffic
// against a value-level model, on 8- and 16-byte output instances.
module tb_quad_byte_assembler;
    import quad_byte_assembler_pkg::*;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_byte;
    data_type_t   data_type;
    logic         sign_ext;
    logic         align_high;
    logic         abort;
    logic         out_ready;

    logic         in_ready8;
    logic         out_valid8;
    logic [63:0]  data_out8;
    logic [3:0]   byte_cnt8;
    logic         in_ready16;
    logic         out_valid16;
    logic [127:0] data_out16;
    logic [3:0]   byte_cnt16;

    int n_checks = 0;
    int n_fail   = 0;

    quad_byte_assembler u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_byte(in_byte), .data_type(data_type), .sign_ext(sign_ext),
        .align_high(align_high), .abort(abort), .out_valid(out_valid8),
        .out_ready(out_ready), .data_out(data_out8), .byte_cnt(byte_cnt8)
    );

    quad_byte_assembler #(.OUT_BYTES(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_byte(in_byte), .data_type(data_type), .sign_ext(sign_ext),
        .align_high(align_high), .abort(abort), .out_valid(out_valid16),
        .out_ready(out_ready), .data_out(data_out16), .byte_cnt(byte_cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        case (t)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [127:0] fmt(input logic [63:0] acc, input int n,
                                         input bit sx, input bit ah,
                                         input int ob);
        logic [127:0] v;
        logic [127:0] r;
        v = {64'd0, acc};
        if (ah)
            r = v << (ob*8 - n*8);
        else if (sx && v[n*8-1])
            r = v | ~((128'd1 << (n*8)) - 128'd1);
        else
            r = v;
        if (ob == 8) r[127:64] = '0;
        return r;
    endfunction

    bit           m_known = 0;
    bit           m_hold  = 0;
    int           m_cnt   = 0;
    int           m_n     = 8;
    bit           m_sx    = 0;
    bit           m_ah    = 0;
    logic [63:0]  m_acc   = '0;
    logic [63:0]  m_exp8  = '0;
    logic [127:0] m_exp16 = '0;

    // Inputs change at posedge+1, so at negedge they are what the next edge sees.
    always @(negedge clk) begin
        if (m_known) begin
            chk("in_ready8",   128'(in_ready8),   128'(!m_hold && !abort));
            chk("out_valid8",  128'(out_valid8),  128'(m_hold && !abort));
            chk("byte_cnt8",   128'(byte_cnt8),   128'(m_cnt));
            chk("data_out8",   128'(data_out8),   128'(m_exp8));
            chk("in_ready16",  128'(in_ready16),  128'(!m_hold && !abort));
            chk("out_valid16", 128'(out_valid16), 128'(m_hold && !abort));
            chk("byte_cnt16",  128'(byte_cnt16),  128'(m_cnt));
            chk("data_out16",  data_out16,        m_exp16);
        end
        if (rst) begin
            m_known = 1;
            m_hold  = 0;
            m_cnt   = 0;
            m_exp8  = '0;
            m_exp16 = '0;
        end else if (m_known) begin
            if (abort) begin
                m_hold = 0;
                m_cnt  = 0;
            end else if (m_hold) begin
                if (out_ready) begin
                    m_hold = 0;
                    m_cnt  = 0;
                end
            end else if (in_valid) begin
                if (m_cnt == 0) begin
                    m_n   = nbytes(data_type);
                    m_sx  = sign_ext;
                    m_ah  = align_high;
                    m_acc = '0;
                end
                m_acc = m_acc * 256 + 64'(in_byte);
                m_cnt++;
                if (m_cnt == m_n) begin
                    m_hold  = 1;
                    m_exp16 = fmt(m_acc, m_n, m_sx, m_ah, 16);
                    m_exp8  = fmt(m_acc, m_n, m_sx, m_ah, 8)[63:0];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_byte = 0; data_type = RAM_BYTE;
        sign_ext = 0; align_high = 0; abort = 0; out_ready = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 128'(in_ready8), 128'd1);
        chk("rst_out_valid", 128'(out_valid8), 128'd0);
        chk("rst_byte_cnt", 128'(byte_cnt8), 128'd0);
        chk("rst_data", 128'(data_out8), 128'd0);

        data_type = RAM_BYTE; sign_ext = 1;
        put(8'h80);
        chk("byte_sx_valid", 128'(out_valid8), 128'd1);
        chk("byte_sx_cnt", 128'(byte_cnt8), 128'd1);
        chk("byte_sx", 128'(data_out8), 128'h00000000_00000000_FFFFFFFF_FFFFFF80);
        chk("model_byte_sx", 128'(m_exp8), 128'h0000000000000000_FFFFFFFFFFFFFF80);
        take();
        sign_ext = 0;
        put(8'h80);
        chk("byte_zx", 128'(data_out8), 128'h80);
        take();

        data_type = RAM_WORD; align_high = 1;
        put(8'h12);
        tick(); tick();
        put(8'h34);
        chk("word_hi", 128'(data_out8), 128'h1234000000000000);
        chk("word_hi16", data_out16, 128'h1234_0000000000000000_000000000000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 128'(out_valid8), 128'd1);
            chk("hold_ready", 128'(in_ready8), 128'd0);
            chk("hold_data", 128'(data_out8), 128'h1234000000000000);
        end
        take();
        chk("post_hs_ready", 128'(in_ready8), 128'd1);
        chk("post_hs_cnt", 128'(byte_cnt8), 128'd0);

        data_type = RAM_QUAD; align_high = 0;
        put(8'h01);
        data_type = RAM_BYTE;
        for (int i = 2; i <= 8; i++) begin
            chk("quad_not_done", 128'(out_valid8), 128'd0);
            put(8'(i));
        end
        chk("quad", 128'(data_out8), 128'h0102030405060708);
        chk("quad_cnt", 128'(byte_cnt8), 128'd8);
        take();

        data_type = RAM_LONG; sign_ext = 1;
        put(8'hDE); put(8'hAD);
        abort = 1; in_valid = 1; in_byte = 8'h55;
        tick();
        abort = 0; in_valid = 0;
        chk("abort_cnt", 128'(byte_cnt8), 128'd0);
        put(8'h00); put(8'h00); put(8'h00);
        chk("long_pending", 128'(out_valid8), 128'd0);
        put(8'h7F);
        chk("long_7f", 128'(data_out8), 128'h7F);
        chk("long_7f16", data_out16, 128'h7F);
        take();

        put(8'hA0); put(8'h01); put(8'h02); put(8'h03);
        chk("long_neg", 128'(data_out8), 128'hFFFFFFFFA0010203);
        abort = 1; out_ready = 1;
        tick();
        abort = 0; out_ready = 0;
        chk("hold_abort_valid", 128'(out_valid8), 128'd0);
        chk("hold_abort_cnt", 128'(byte_cnt8), 128'd0);

        put(8'h11); put(8'h22);
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_cnt", 128'(byte_cnt8), 128'd0);
        chk("midrst_data", 128'(data_out8), 128'd0);
        chk("midrst_ready", 128'(in_ready8), 128'd1);
        sign_ext = 0;
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        chk("fresh_long", 128'(data_out8), 128'h11223344);
        take();

        sign_ext = 1;
        put(8'h80); put(8'h00); put(8'h00); put(8'h01);
        chk("long16_sx", data_out16,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_80000001);
        chk("long8_sx", 128'(data_out8), 128'hFFFFFFFF80000001);
        chk("model_long16", m_exp16,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_80000001);
        take();

        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(199) == 0);
            abort      = ($urandom_range(24) == 0);
            in_valid   = $urandom_range(1);
            out_ready  = ($urandom_range(9) < 4);
            in_byte    = 8'($urandom);
            data_type  = 3'($urandom);
            sign_ext   = $urandom_range(1);
            align_high = $urandom_range(1);
            tick();
        end
        rst = 0; abort = 0; in_valid = 0; out_ready = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
